// File: rtl/crc5_frame_ctrl_if.sv
// Frame-check handshake between the bit decoder / command parser (master)
// and the CRC-5 frame controller (slave).
interface crc5_frame_ctrl_if #(
   parameter int LEN_W = 6
);
   logic             start;
   logic [LEN_W-1:0] len_in;
   logic             abort;
   logic             bit_valid;
   logic             bit_in;
   logic             busy;
   logic             done;
   logic             crc_ok;
   logic             crc_err;
   logic [1:0]       err_code;
   logic [LEN_W-1:0] bit_count;
   logic [4:0]       crc_val;

   modport master (
      output start, len_in, abort, bit_valid, bit_in,
      input  busy, done, crc_ok, crc_err, err_code, bit_count, crc_val
   );

   modport slave (
      input  start, len_in, abort, bit_valid, bit_in,
      output busy, done, crc_ok, crc_err, err_code, bit_count, crc_val
   );
endinterface

// File: rtl/crc5_frame_ctrl.sv
// CRC-5 (x^5+x^3+1) check sequencer for one received command frame at a time.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; verdict flags from last frame held
//   ARM   | preset CRC register to 01001
//   RUN   | waiting for the next bit_valid strobe
//   GAP   | one-cycle rate guard after each bit; overrun if a bit arrives
//   CHECK | evaluate residue once all bits are in
//   DONE  | done pulse; verdict valid
module crc5_frame_ctrl #(
   parameter int LEN_W   = 6,
   parameter int MIN_LEN = 6
) (
   input  logic             clk,
   input  logic             reset_n,
   crc5_frame_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARM   = 3'd1,
      S_RUN   = 3'd2,
      S_GAP   = 3'd3,
      S_CHECK = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam logic [4:0]       CRC_PRESET = 5'b01001;
   localparam logic [LEN_W-1:0] MIN_LEN_L  = LEN_W'(MIN_LEN);
   localparam logic [LEN_W-1:0] ZERO_LEN   = '0;
   localparam logic [1:0]       ERR_NONE   = 2'b00;
   localparam logic [1:0]       ERR_RES    = 2'b01;
   localparam logic [1:0]       ERR_LEN    = 2'b10;
   localparam logic [1:0]       ERR_OVR    = 2'b11;

   state_t           state_q, state_d;
   logic [4:0]       crc_q, crc_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic             ok_q, ok_d;
   logic             err_q, err_d;
   logic [1:0]       code_q, code_d;
   logic             fb;
   logic [4:0]       crc_shift;

   assign fb        = bus.bit_in ^ crc_q[4];
   assign crc_shift = {crc_q[3], crc_q[2] ^ fb, crc_q[1], crc_q[0], fb};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         crc_q   <= CRC_PRESET;
         cnt_q   <= '0;
         rem_q   <= '0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
         code_q  <= code_d;
      end
   end

   // rem_q counts down the bits still owed; terminal count selects CHECK.
   always_comb begin
      state_d = state_q;
      crc_d   = crc_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      ok_d    = ok_q;
      err_d   = err_q;
      code_d  = code_q;

      if (bus.abort) begin
         state_d = S_IDLE;
         crc_d   = CRC_PRESET;
         cnt_d   = '0;
         rem_d   = '0;
         ok_d    = 1'b0;
         err_d   = 1'b0;
         code_d  = ERR_NONE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  ok_d  = 1'b0;
                  cnt_d = '0;
                  if (bus.len_in >= MIN_LEN_L) begin
                     state_d = S_ARM;
                     rem_d   = bus.len_in;
                     err_d   = 1'b0;
                     code_d  = ERR_NONE;
                  end else begin
                     state_d = S_DONE;
                     rem_d   = '0;
                     err_d   = 1'b1;
                     code_d  = ERR_LEN;
                  end
               end
            end
            S_ARM: begin
               crc_d   = CRC_PRESET;
               state_d = S_RUN;
            end
            S_RUN: begin
               if (bus.bit_valid) begin
                  crc_d   = crc_shift;
                  cnt_d   = cnt_q + 1'b1;
                  rem_d   = rem_q - 1'b1;
                  state_d = S_GAP;
               end
            end
            S_GAP: begin
               if (bus.bit_valid) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
                  code_d  = ERR_OVR;
               end else if (rem_q == ZERO_LEN) begin
                  state_d = S_CHECK;
               end else begin
                  state_d = S_RUN;
               end
            end
            S_CHECK: begin
               if (crc_q == 5'b00000) begin
                  ok_d = 1'b1;
               end else begin
                  err_d  = 1'b1;
                  code_d = ERR_RES;
               end
               state_d = S_DONE;
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_DONE);
   assign bus.crc_ok    = ok_q;
   assign bus.crc_err   = err_q;
   assign bus.err_code  = code_q;
   assign bus.bit_count = cnt_q;
   assign bus.crc_val   = crc_q;

endmodule

// File: tb/tb_crc5_frame_ctrl.sv
// Directed bench for crc5_frame_ctrl: good/corrupt frames, length and rate
// errors, abort, async reset and start-while-busy.
module tb_crc5_frame_ctrl;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_fail;

   crc5_frame_ctrl_if #(.LEN_W(6)) bus ();

   crc5_frame_ctrl #(.LEN_W(6), .MIN_LEN(6)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic       good_bits [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
   logic [4:0] good_crc  [6] = '{5'b10010, 5'b00100, 5'b01000, 5'b10000, 5'b00000, 5'b00000};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one bit for a single sampling edge; returns in GAP.
   task automatic send_bit(input logic b);
      bus.bit_valid = 1'b1;
      bus.bit_in    = b;
      tick();
      bus.bit_valid = 1'b0;
      bus.bit_in    = 1'b0;
   endtask

   task automatic start_frame(input logic [5:0] len);
      bus.start  = 1'b1;
      bus.len_in = len;
      tick();
      bus.start  = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus.start = 1'b0; bus.len_in = '0; bus.abort = 1'b0;
      bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
      tick(); tick();
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
      n_checks++; if ({bus.crc_ok, bus.crc_err, bus.err_code} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {bus.crc_ok, bus.crc_err, bus.err_code}); end
      n_checks++; if (bus.bit_count !== 6'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.bit_count); end
      n_checks++; if (bus.crc_val !== 5'b01001) begin n_fail++; $display("FAIL reset_crc got %b want 01001", bus.crc_val); end
      reset_n = 1'b1;
      tick();
      send_bit(1'b1);
      n_checks++; if (bus.crc_val !== 5'b01001) begin n_fail++; $display("FAIL idle_bit_crc got %b want 01001", bus.crc_val); end
      n_checks++; if (bus.bit_count !== 6'd0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_bit_count got %0d busy %b want 0 0", bus.bit_count, bus.busy); end
      tick();
   endtask

   task automatic test_good_frame();
      start_frame(6'd6);
      n_checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin n_fail++; $display("FAIL good_arm busy %b done %b want 1 0", bus.busy, bus.done); end
      tick();
      for (int i = 0; i < 6; i++) begin
         send_bit(good_bits[i]);
         n_checks++; if (bus.crc_val !== good_crc[i]) begin n_fail++; $display("FAIL good_crc bit %0d got %b want %b", i, bus.crc_val, good_crc[i]); end
         n_checks++; if (bus.bit_count !== 6'(i + 1)) begin n_fail++; $display("FAIL good_count bit %0d got %0d want %0d", i, bus.bit_count, i + 1); end
         tick();
      end
      n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL good_check_state done %b busy %b want 0 1", bus.done, bus.busy); end
      tick();
      n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL good_done got %b want 1", bus.done); end
      n_checks++; if ({bus.crc_ok, bus.crc_err, bus.err_code} !== 4'b1000) begin n_fail++; $display("FAIL good_verdict got %b want 1000", {bus.crc_ok, bus.crc_err, bus.err_code}); end
      tick();
      n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.crc_ok !== 1'b1) begin n_fail++; $display("FAIL good_hold done %b busy %b ok %b want 0 0 1", bus.done, bus.busy, bus.crc_ok); end
   endtask

   task automatic test_corrupt_frame();
      int done_seen;
      done_seen = 0;
      start_frame(6'd6);
      tick();
      for (int i = 0; i < 6; i++) begin
         send_bit(i == 5 ? 1'b1 : good_bits[i]);
         tick();
      end
      n_checks++; if (bus.crc_val !== 5'b01001) begin n_fail++; $display("FAIL corrupt_crc got %b want 01001", bus.crc_val); end
      for (int c = 0; c < 4; c++) begin
         if (bus.done === 1'b1) done_seen++;
         if (c == 1) begin
            n_checks++; if ({bus.crc_ok, bus.crc_err, bus.err_code} !== 4'b0101) begin n_fail++; $display("FAIL corrupt_verdict got %b want 0101", {bus.crc_ok, bus.crc_err, bus.err_code}); end
         end
         tick();
      end
      n_checks++; if (done_seen != 1) begin n_fail++; $display("FAIL corrupt_done_pulses got %0d want 1", done_seen); end
      n_checks++; if (bus.crc_err !== 1'b1 || bus.err_code !== 2'b01) begin n_fail++; $display("FAIL corrupt_hold err %b code %b want 1 01", bus.crc_err, bus.err_code); end
   endtask

   task automatic test_bad_length();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      start_frame(6'd5);
      n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL badlen_done got %b want 1", bus.done); end
      n_checks++; if ({bus.crc_ok, bus.crc_err, bus.err_code} !== 4'b0110) begin n_fail++; $display("FAIL badlen_verdict got %b want 0110", {bus.crc_ok, bus.crc_err, bus.err_code}); end
      n_checks++; if (bus.crc_val !== 5'b01001 || bus.bit_count !== 6'd0) begin n_fail++; $display("FAIL badlen_noshift crc %b count %0d want 01001 0", bus.crc_val, bus.bit_count); end
      tick();
      n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.crc_err !== 1'b1) begin n_fail++; $display("FAIL badlen_after done %b busy %b err %b want 0 0 1", bus.done, bus.busy, bus.crc_err); end
   endtask

   task automatic test_overrun();
      start_frame(6'd6);
      tick();
      bus.bit_valid = 1'b1;
      bus.bit_in    = 1'b0;
      tick();
      tick();
      bus.bit_valid = 1'b0;
      n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL overrun_done got %b want 1", bus.done); end
      n_checks++; if ({bus.crc_ok, bus.crc_err, bus.err_code} !== 4'b0111) begin n_fail++; $display("FAIL overrun_verdict got %b want 0111", {bus.crc_ok, bus.crc_err, bus.err_code}); end
      n_checks++; if (bus.bit_count !== 6'd1) begin n_fail++; $display("FAIL overrun_count got %0d want 1", bus.bit_count); end
      tick();
   endtask

   task automatic test_abort();
      logic [9:0] pat;
      pat = 10'b1011001110;
      start_frame(6'd22);
      tick();
      for (int i = 0; i < 10; i++) begin
         send_bit(pat[9 - i]);
         tick();
      end
      n_checks++; if (bus.bit_count !== 6'd10 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre count %0d busy %b want 10 1", bus.bit_count, bus.busy); end
      bus.abort = 1'b1;
      bus.start = 1'b1;
      bus.len_in = 6'd6;
      tick();
      bus.abort = 1'b0;
      bus.start = 1'b0;
      n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_busy busy %b done %b want 0 0", bus.busy, bus.done); end
      n_checks++; if (bus.bit_count !== 6'd0 || bus.crc_val !== 5'b01001) begin n_fail++; $display("FAIL abort_clear count %0d crc %b want 0 01001", bus.bit_count, bus.crc_val); end
      tick();
      n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_nodone busy %b done %b want 0 0", bus.busy, bus.done); end
      test_good_frame();
      start_frame(6'd63);
      n_checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.crc_err !== 1'b0) begin n_fail++; $display("FAIL maxlen_accept busy %b done %b err %b want 1 0 0", bus.busy, bus.done, bus.crc_err); end
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
   endtask

   task automatic test_async_reset_busy_start();
      start_frame(6'd6);
      tick();
      for (int i = 0; i < 6; i++) begin
         send_bit(good_bits[i]);
         tick();
         if (i == 1) begin
            start_frame(6'd22);
            n_checks++; if (bus.busy !== 1'b1 || bus.bit_count !== 6'd2 || bus.crc_val !== 5'b00100) begin n_fail++; $display("FAIL busy_start busy %b count %0d crc %b want 1 2 00100", bus.busy, bus.bit_count, bus.crc_val); end
         end
      end
      tick();
      n_checks++; if (bus.done !== 1'b1 || bus.crc_ok !== 1'b1) begin n_fail++; $display("FAIL busy_start_len done %b ok %b want 1 1", bus.done, bus.crc_ok); end
      tick();
      start_frame(6'd6);
      tick();
      for (int i = 0; i < 6; i++) begin
         send_bit(good_bits[i]);
         tick();
      end
      n_checks++; if (bus.busy !== 1'b1 || bus.bit_count !== 6'd6) begin n_fail++; $display("FAIL prereset busy %b count %0d want 1 6", bus.busy, bus.bit_count); end
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL async_reset busy %b done %b want 0 0", bus.busy, bus.done); end
      n_checks++; if (bus.bit_count !== 6'd0 || bus.crc_val !== 5'b01001 || {bus.crc_ok, bus.crc_err, bus.err_code} !== 4'b0000) begin n_fail++; $display("FAIL async_reset_vals count %0d crc %b flags %b want 0 01001 0000", bus.bit_count, bus.crc_val, {bus.crc_ok, bus.crc_err, bus.err_code}); end
      tick();
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL postreset cycle %0d done %b busy %b want 0 0", c, bus.done, bus.busy); end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_good_frame();
      test_corrupt_frame();
      test_bad_length();
      test_overrun();
      test_abort();
      test_async_reset_busy_start();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/crc5_frame_ctrl.md
Name: crc5_frame_ctrl

Overview:
- Sequences CRC-5 checking of one received command frame at a time in the tag receive path.
- Per frame: presets the CRC-5 register, shifts exactly len_in bits (payload plus the 5 transmitted CRC bits), waits for the register to settle, then flags pass or fail on a zero residue.
- Sits between the bit decoder and the command parser (Query frames: len_in = 22). Contains its own CRC-5 register.

Parameters:
- LEN_W, 6, width of len_in and bit_count.
- MIN_LEN, 6, minimum legal frame length (1 payload bit + 5 CRC bits).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame check, samples len_in.
- len_in  in  LEN_W  total frame bits including CRC.
- abort  in  1  cancel current frame; highest priority.
- bit_valid  in  1  one-cycle strobe, bit_in valid.
- bit_in  in  1  serial frame bit, MSB first.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the verdict becomes valid.
- crc_ok  out  1  residue == 0; held until next start or abort.
- crc_err  out  1  bad residue, bad length or overrun; held like crc_ok.
- err_code  out  2  00 none, 01 residue, 10 length, 11 overrun.
- bit_count  out  LEN_W  bits accepted in the current frame.
- crc_val  out  5  current CRC register, for debug and the parser.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state IDLE; crc_val = 5'b01001.
  - All other outputs 0.
- CRC register (poly x^5+x^3+1):
  - Preset value: 01001.
  - On each shift, with fb = bit_in ^ crc[4]: crc[0] <= fb; crc[1] <= crc[0]; crc[2] <= crc[1]; crc[3] <= crc[2]^fb; crc[4] <= crc[3].
- IDLE:
  - start with len_in >= MIN_LEN: go to ARM, latch len_in, clear crc_ok, crc_err, err_code and bit_count.
  - start with len_in < MIN_LEN: go to DONE with crc_err = 1, err_code = 10.
- ARM (1 cycle): crc <= 01001; go to RUN.
- RUN: on bit_valid, shift the CRC, bit_count++, go to GAP. Otherwise wait indefinitely.
- GAP (1 cycle, rate guard):
  - bit_valid here: overrun; go to DONE with crc_err = 1, err_code = 11.
  - Else if bit_count == latched length: go to CHECK.
  - Else: go to RUN.
  - Consequence: minimum bit spacing is 2 cycles.
- CHECK (1 cycle): crc_val == 0 sets crc_ok; otherwise crc_err with err_code = 01. Go to DONE.
- DONE (1 cycle): done = 1; go to IDLE. crc_ok and crc_err persist.
- Latency: the verdict (done) arrives exactly 3 cycles after the clk edge that samples the last bit_valid (GAP, CHECK, DONE).
- start while busy: ignored.
- bit_valid in IDLE, ARM, CHECK or DONE: ignored, no shift.
- abort, any state:
  - Next state IDLE; crc <= 01001; flags and bit_count cleared.
  - No done pulse.
  - abort and start in the same cycle: abort wins.
- bit_count never exceeds the latched length; no wrap.
- len_in = 2^LEN_W - 1 is legal.
- Reset mid-frame: immediate return to reset values; no done pulse.

Test Plan:
- Good minimal frame: start, len_in = 6; bits 0,1,0,0,1,0 spaced 2 cycles -> crc_val after each bit: 10010, 00100, 01000, 10000, 00000, 00000; done 3 cycles after last bit; crc_ok = 1, err_code = 00.
- Corrupt frame: same stimulus but last bit = 1 -> final crc_val = 01001, crc_err = 1, err_code = 01, done pulses once.
- Bad length: start with len_in = 5 -> done on 2nd cycle after start, crc_err = 1, err_code = 10, no shifts, crc_val stays 01001.
- Overrun: len_in = 6, bit_valid on two consecutive cycles -> crc_err = 1, err_code = 11, bit_count = 1.
- Abort mid-frame: len_in = 22, abort after 10 bits -> busy = 0 next cycle, bit_count = 0, crc_val = 01001, no done. A following good 6-bit frame passes.
- Async reset mid-CHECK, plus start while busy: pull reset_n low between clock edges -> outputs reset without a clock edge. Issue start during RUN -> ignored; latched length unchanged.
